output_writeback_unit: RTL and testbench

//  Downstream of processing_unit. Sums the per-tile output_vals that processing_unit produces over

---
 rtl/output_writeback_unit_if.sv | 14 +
 rtl/output_writeback_unit.sv | 152 +++++++++++++++
 tb/tb_output_writeback_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/output_writeback_unit_if.sv
// Drain stream from the writeback unit to the activation memory writer.
// The master drives valid/data/addr and the slave returns ready.
interface output_writeback_unit_if #(
  parameter int ACC_LEN  = 32,
  parameter int ADDR_LEN = 3
);
  logic                out_valid;
  logic                out_ready;
  logic [ACC_LEN-1:0]  out_data;
  logic [ADDR_LEN-1:0] out_addr;

  modport master (output out_valid, output out_data, output out_addr, input out_ready);
  modport slave  (input out_valid, input out_data, input out_addr, output out_ready);
endinterface

// File: rtl/output_writeback_unit.sv
// Accumulates processing_unit tiles into a saturating partial-sum buffer, then drains it in raster order.
// Optional macro RELU_EN clamps negative partial sums to zero on the drain path only.
`ifndef OUTPUT_CHANNEL
`define OUTPUT_CHANNEL 2
`endif
`ifndef OUTPUT_HEIGHT
`define OUTPUT_HEIGHT 2
`endif
`ifndef OUTPUT_WIDTH
`define OUTPUT_WIDTH 2
`endif
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 16
`endif

module output_writeback_unit #(
  parameter int OC       = `OUTPUT_CHANNEL,
  parameter int OH       = `OUTPUT_HEIGHT,
  parameter int OW       = `OUTPUT_WIDTH,
  parameter int IN_LEN   = `OUT_BIN_LEN,
  parameter int ACC_LEN  = 32,
  parameter int ADDR_LEN = $clog2(OC*OH*OW)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [IN_LEN-1:0] tile_vals [OC][OH][OW],
  input  logic                     tile_done,
  input  logic                     tile_last,
  output logic                     tile_ack,
  output logic                     busy,
  output logic                     layer_done,
  output_writeback_unit_if.master  drain
);

  localparam int N = OC*OH*OW;
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(N-1);
  localparam logic signed [ACC_LEN-1:0] ACC_MAX = {1'b0, {(ACC_LEN-1){1'b1}}};
  localparam logic signed [ACC_LEN-1:0] ACC_MIN = {1'b1, {(ACC_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_LOW,
    S_DRAIN
  } state_t;

  state_t                     state_reg, state_next;
  logic                       last_reg;
  logic signed [ACC_LEN-1:0]  acc_reg [N];
  logic signed [ACC_LEN-1:0]  acc_sum [N];
  logic [ADDR_LEN-1:0]        out_addr_reg;
  logic [ADDR_LEN-1:0]        addr_next;
  logic signed [ACC_LEN-1:0]  out_data_reg;
  logic                       layer_done_reg;
  logic                       accumulate;
  logic                       handshake;
  logic                       final_beat;
  logic                       start_drain;
  logic                       load_out;

  // One guard bit above ACC_LEN makes overflow visible as a sign-bit disagreement.
  function automatic logic signed [ACC_LEN-1:0] sat_add(
    input logic signed [ACC_LEN-1:0] a,
    input logic signed [IN_LEN-1:0]  b
  );
    logic signed [ACC_LEN:0] s;
    s = {a[ACC_LEN-1], a} + {{(ACC_LEN+1-IN_LEN){b[IN_LEN-1]}}, b};
    if (s[ACC_LEN] != s[ACC_LEN-1])
      return s[ACC_LEN] ? ACC_MIN : ACC_MAX;
    return s[ACC_LEN-1:0];
  endfunction

  function automatic logic signed [ACC_LEN-1:0] drain_view(input logic signed [ACC_LEN-1:0] x);
`ifdef RELU_EN
    return x[ACC_LEN-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  always_comb begin
    accumulate  = (state_reg == S_IDLE) && tile_done;
    handshake   = (state_reg == S_DRAIN) && drain.out_ready;
    final_beat  = handshake && (out_addr_reg == LAST_ADDR);
    start_drain = (state_reg == S_WAIT_LOW) && !tile_done && last_reg;
    load_out    = start_drain || (handshake && !final_beat);
    addr_next   = start_drain ? '0 : out_addr_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (tile_done) state_next = S_ACK;
      S_ACK:      state_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!tile_done) state_next = last_reg ? S_DRAIN : S_IDLE;
      S_DRAIN:    if (final_beat) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      last_reg       <= 1'b0;
      layer_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      layer_done_reg <= final_beat;
      if (accumulate) last_reg <= tile_last;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sum
      localparam int CH = gi / (OH*OW);
      localparam int R  = (gi / OW) % OH;
      localparam int C  = gi % OW;
      assign acc_sum[gi] = sat_add(acc_reg[gi], tile_vals[CH][R][C]);
    end
  endgenerate

  // Clearing each entry as it drains leaves the buffer zeroed for the next layer.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset)
        acc_reg[i] <= '0;
      else if (accumulate)
        acc_reg[i] <= acc_sum[i];
      else if (handshake && (out_addr_reg == ADDR_LEN'(i)))
        acc_reg[i] <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_addr_reg <= '0;
      out_data_reg <= '0;
    end else if (load_out) begin
      out_addr_reg <= addr_next;
      out_data_reg <= drain_view(acc_reg[addr_next]);
    end
  end

  assign tile_ack        = (state_reg == S_ACK);
  assign busy            = (state_reg != S_IDLE);
  assign layer_done      = layer_done_reg;
  assign drain.out_valid = (state_reg == S_DRAIN);
  assign drain.out_data  = out_data_reg;
  assign drain.out_addr  = out_addr_reg;

endmodule

// File: tb/tb_output_writeback_unit.sv
// Randomized self-checking bench for output_writeback_unit against a clamp-and-sum layer model.
`timescale 1ns/1ps
module tb_output_writeback_unit;
  localparam int OC = 2, OH = 2, OW = 2, IN_LEN = 16, ACC_LEN = 20;
  localparam int N = OC*OH*OW;
  localparam int ADDR_LEN = $clog2(N);
  localparam longint SMAX = (longint'(1) <<< (ACC_LEN-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (ACC_LEN-1));

  logic clock = 1'b0;
  logic reset;
  logic signed [IN_LEN-1:0] tile_vals [OC][OH][OW];
  logic tile_done, tile_last, tile_ack, busy, layer_done;

  output_writeback_unit_if #(.ACC_LEN(ACC_LEN), .ADDR_LEN(ADDR_LEN)) drain ();

  output_writeback_unit #(
    .OC(OC), .OH(OH), .OW(OW), .IN_LEN(IN_LEN), .ACC_LEN(ACC_LEN), .ADDR_LEN(ADDR_LEN)
  ) dut (
    .clock(clock), .reset(reset), .tile_vals(tile_vals), .tile_done(tile_done),
    .tile_last(tile_last), .tile_ack(tile_ack), .busy(busy), .layer_done(layer_done),
    .drain(drain)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;
  longint model [N];
  int tile_in [N];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint expect_out(input longint a);
`ifdef RELU_EN
    return (a < 0) ? 0 : a;
`else
    return a;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents tile_in, holds done for `hold` cycles, and folds the tile into the model.
  task automatic send_tile(input string tag, input bit last, input int hold);
    int acks;
    int waited;
    for (int i = 0; i < N; i++) tile_vals[i/(OH*OW)][(i/OW)%OH][i%OW] = tile_in[i][IN_LEN-1:0];
    tile_last = last;
    tile_done = 1'b1;
    tick();
    check({tag, ".ack_latency"}, tile_ack, 1);
    acks = tile_ack;
    for (int k = 1; k < hold; k++) begin
      tick();
      acks += tile_ack;
    end
    tile_done = 1'b0;
    tile_last = 1'b0;
    waited = 0;
    do begin
      tick();
      acks += tile_ack;
      waited++;
    end while (busy && !drain.out_valid && waited < 6);
    check({tag, ".ack_count"}, acks, 1);
    check({tag, ".after_tile"}, last ? drain.out_valid : busy, last ? 1 : 0);
    for (int i = 0; i < N; i++) begin
      model[i] = model[i] + tile_in[i];
      if (model[i] > SMAX) model[i] = SMAX;
      if (model[i] < SMIN) model[i] = SMIN;
    end
  endtask

  // mode 0: ready always; 1: pattern 1,0,0; 2: random. Stops early before beat stop_at.
  task automatic drain_layer(input string tag, input int mode, input int stop_at);
    int e = 0;
    int cyc = 0;
    bit rdy;
    while (e < stop_at && cyc < 200) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      drain.out_ready = rdy;
      check({tag, ".valid"}, drain.out_valid, 1);
      check({tag, ".addr"}, drain.out_addr, e);
      check({tag, ".data"}, longint'($signed(drain.out_data)), expect_out(model[e]));
      if (e != stop_at - 1 || stop_at == N)
        $display("%s beat addr=%0d data=%0d ready=%0d", tag, drain.out_addr, $signed(drain.out_data), rdy);
      tick();
      if (rdy) e++;
      cyc++;
    end
    drain.out_ready = 1'b0;
    check({tag, ".beats_done"}, e, stop_at);
    if (stop_at < N) return;
    if (mode == 0) check({tag, ".zero_bubble"}, cyc, N);
    check({tag, ".valid_end"}, drain.out_valid, 0);
    check({tag, ".layer_done"}, layer_done, 1);
    check({tag, ".busy_end"}, busy, 0);
    for (int i = 0; i < N; i++) model[i] = 0;
    tick();
    check({tag, ".layer_done_pulse"}, layer_done, 0);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) tile_in[i] = v;
  endtask

  initial begin
    int ntiles, hold, mode;
    reset = 1'b1;
    tile_done = 1'b0;
    tile_last = 1'b0;
    drain.out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      model[i] = 0;
      tile_vals[i/(OH*OW)][(i/OW)%OH][i%OW] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;
    check("reset.tile_ack", tile_ack, 0);
    check("reset.busy", busy, 0);
    check("reset.valid", drain.out_valid, 0);
    check("reset.data", drain.out_data, 0);
    check("reset.addr", drain.out_addr, 0);
    check("reset.layer_done", layer_done, 0);
    tick();

    for (int i = 0; i < N; i++) tile_in[i] = i + 1;
    send_tile("t1", 1, 1);
    drain_layer("t1", 0, N);

    fill(5);
    send_tile("t2a", 0, 4);
    send_tile("t2b", 0, 4);
    send_tile("t2c", 1, 4);
    drain_layer("t2", 0, N);

    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < N; i++) tile_in[i] = (i % 2 == 0) ? 32767 : -32768;
      send_tile("t3", k == 16, 1);
    end
    drain_layer("t3", 0, N);

    for (int i = 0; i < N; i++) tile_in[i] = 10 * i - 20;
    send_tile("t4", 1, 2);
    drain_layer("t4", 1, N);

    fill(9);
    send_tile("t5", 1, 1);
    drain_layer("t5", 0, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5.reset_valid", drain.out_valid, 0);
    check("t5.reset_busy", busy, 0);
    for (int i = 0; i < N; i++) model[i] = 0;
    fill(2);
    send_tile("t5b", 1, 1);
    drain_layer("t5b", 0, N);

    tile_in = '{-3, 4, -1, 0, 7, -8, 2, 1};
    send_tile("t6", 1, 3);
    drain_layer("t6", 2, N);

    for (int layer = 0; layer < 10; layer++) begin
      ntiles = $urandom_range(1, 4);
      for (int t = 0; t < ntiles; t++) begin
        for (int i = 0; i < N; i++) tile_in[i] = int'($signed(16'($urandom)));
        hold = $urandom_range(1, 5);
        send_tile("rnd", t == ntiles - 1, hold);
      end
      mode = $urandom_range(0, 2);
      drain_layer("rnd", mode, N);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
